// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational ROM and registers the decoded fields.
// Latency: decode outputs appear 1 cycle after Read_Address presents the instruction; 1 instr/cycle.
// Backpressure: stall freezes PC and decode regs; IFD_HALT_EN adds a HALT state on self-jumps.
module instr_fetch_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            stall,
    output logic [PC_W-1:0] Read_Address,
    input  logic [7:0]      Instruction,
    output logic            instr_valid,
    output logic [1:0]      opcode,
    output logic [1:0]      rs,
    output logic [1:0]      rt,
    output logic [1:0]      rd,
    output logic [7:0]      imm,
    output logic            is_jump,
    output logic [PC_W-1:0] pc_out,
    output logic            halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_out_q, pc_out_d;
    logic            instr_valid_q, instr_valid_d;
    logic [1:0]      opcode_q, opcode_d;
    logic [1:0]      rs_q, rs_d;
    logic [1:0]      rt_q, rt_d;
    logic [1:0]      rd_q, rd_d;
    logic [7:0]      imm_q, imm_d;
    logic            is_jump_q, is_jump_d;
    logic            fetch_jump;
    logic [PC_W-1:0] jump_off;
    logic [PC_W-1:0] next_pc;
`ifdef IFD_HALT_EN
    logic            halted_q, halted_d;
`endif

    // Target arithmetic wraps modulo 2^PC_W; the offset is relative to PC+1.
    always_comb begin
        fetch_jump = (Instruction[7:6] == 2'b11);
        jump_off   = PC_W'($signed(Instruction[5:0]));
        next_pc    = pc_q + PC_W'(1) + (fetch_jump ? jump_off : '0);
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = 1'b0;
        opcode_d      = opcode_q;
        rs_d          = rs_q;
        rt_d          = rt_q;
        rd_d          = rd_q;
        imm_d         = imm_q;
        is_jump_d     = is_jump_q;
`ifdef IFD_HALT_EN
        halted_d      = halted_q;
`endif
        case (state_q)
            IDLE: begin
                if (run) state_d = RUN;
            end
            RUN: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (!stall) begin
                    instr_valid_d = 1'b1;
                    pc_out_d      = pc_q;
                    pc_d          = next_pc;
                    opcode_d      = Instruction[7:6];
                    rs_d          = Instruction[5:4];
                    rt_d          = Instruction[3:2];
                    rd_d          = Instruction[1:0];
                    imm_d         = {{6{Instruction[1]}}, Instruction[1:0]};
                    is_jump_d     = fetch_jump;
`ifdef IFD_HALT_EN
                    // A self-loop leaves next_pc equal to pc_q, so PC already parks on the jump.
                    if (fetch_jump && (Instruction[5:0] == 6'h3F)) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end
`endif
                end
            end
`ifdef IFD_HALT_EN
            HALT: begin
                state_d = HALT;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            pc_out_q      <= '0;
            instr_valid_q <= 1'b0;
            opcode_q      <= 2'b00;
            rs_q          <= 2'b00;
            rt_q          <= 2'b00;
            rd_q          <= 2'b00;
            imm_q         <= 8'h00;
            is_jump_q     <= 1'b0;
`ifdef IFD_HALT_EN
            halted_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
            opcode_q      <= opcode_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            rd_q          <= rd_d;
            imm_q         <= imm_d;
            is_jump_q     <= is_jump_d;
`ifdef IFD_HALT_EN
            halted_q      <= halted_d;
`endif
        end
    end

    assign Read_Address = pc_q;
    assign instr_valid  = instr_valid_q;
    assign opcode       = opcode_q;
    assign rs           = rs_q;
    assign rt           = rt_q;
    assign rd           = rd_q;
    assign imm          = imm_q;
    assign is_jump      = is_jump_q;
    assign pc_out       = pc_out_q;
`ifdef IFD_HALT_EN
    assign halted       = halted_q;
`else
    assign halted       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed programs, expected decodes queued up front and popped by a monitor.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, run, stall, run_w;
    logic [7:0] rom   [256];
    logic [7:0] rom_w [256];

    logic [7:0] ra, instr, imm, pc_out;
    logic [1:0] opcode, rs, rt, rd;
    logic       iv, is_jump, halted;

    logic [7:0] ra_w, instr_w, imm_w, pc_out_w;
    logic [1:0] opcode_w, rs_w, rt_w, rd_w;
    logic       iv_w, is_jump_w, halted_w;

    assign instr   = rom[ra];
    assign instr_w = rom_w[ra_w];

    instr_fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .run(run), .stall(stall),
        .Read_Address(ra), .Instruction(instr), .instr_valid(iv),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .is_jump(is_jump), .pc_out(pc_out), .halted(halted)
    );

    instr_fetch_unit #(.PC_W(8), .RESET_PC(8'hFE)) dut_w (
        .clk(clk), .reset(reset), .run(run_w), .stall(stall),
        .Read_Address(ra_w), .Instruction(instr_w), .instr_valid(iv_w),
        .opcode(opcode_w), .rs(rs_w), .rt(rt_w), .rd(rd_w), .imm(imm_w),
        .is_jump(is_jump_w), .pc_out(pc_out_w), .halted(halted_w)
    );

    typedef struct packed {
        logic [7:0] pc;
        logic [1:0] op;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [1:0] rd;
        logic [7:0] imm;
        logic       jmp;
        logic [7:0] nra;
    } exp_t;

    exp_t sb[$];
    exp_t mon_a, mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] pc, input logic [1:0] op, input logic [1:0] s,
                        input logic [1:0] t, input logic [1:0] d, input logic [7:0] im,
                        input logic j, input logic [7:0] nra);
        exp_t e;
        e.pc = pc; e.op = op; e.rs = s; e.rt = t; e.rd = d;
        e.imm = im; e.jmp = j; e.nra = nra;
        sb.push_back(e);
    endtask

    // Every valid decode must match the oldest queued expectation, including the next Read_Address.
    always @(negedge clk) begin
        if (iv === 1'b1) begin
            mon_a = '{pc_out, opcode, rs, rt, rd, imm, is_jump, ra};
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_decode: got pc_out=%0h expected no instr_valid", pc_out);
            end else begin
                mon_e = sb.pop_front();
                chk("decode", mon_a, mon_e);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; stall = 1'b0; run_w = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One edge to leave IDLE, n capture edges, then one edge back to IDLE.
    task automatic run_n(input int n);
        run = 1'b1;
        repeat (n + 1) @(posedge clk);
        #1 run = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i]   = 8'h00;
            rom_w[i] = 8'h00;
        end
        rom[0] = 8'h44; rom[1] = 8'h49; rom[2] = 8'h2A; rom[3] = 8'hC2;
        rom[6] = 8'h1B; rom[7] = 8'h00;
        rom_w[8'hFE] = 8'h41; rom_w[8'hFF] = 8'h12; rom_w[8'h00] = 8'h00;

        // Reset state
        do_reset();
        chk("rst_valid", iv, 1'b0);
        chk("rst_fields", {opcode, rs, rt, rd, imm, is_jump}, 17'h0);
        chk("rst_pc_out", pc_out, 8'h00);
        chk("rst_ra", ra, 8'h00);
        chk("rst_halted", halted, 1'b0);

        // Straight-line fetch then PC-relative jump 3 -> 6
        push(8'h00, 2'd1, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 8'h01);
        push(8'h01, 2'd1, 2'd0, 2'd2, 2'd1, 8'h01, 1'b0, 8'h02);
        push(8'h02, 2'd0, 2'd2, 2'd2, 2'd2, 8'hFE, 1'b0, 8'h03);
        push(8'h03, 2'd3, 2'd0, 2'd0, 2'd2, 8'hFE, 1'b1, 8'h06);
        push(8'h06, 2'd0, 2'd1, 2'd2, 2'd3, 8'hFF, 1'b0, 8'h07);
        push(8'h07, 2'd0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 8'h08);
        run_n(6);
        chk("drain_jump", sb.size(), 0);
        chk("idle_hold_ra", ra, 8'h08);

        // Two stall cycles at PC=1
        do_reset();
        push(8'h00, 2'd1, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 8'h01);
        push(8'h01, 2'd1, 2'd0, 2'd2, 2'd1, 8'h01, 1'b0, 8'h02);
        push(8'h02, 2'd0, 2'd2, 2'd2, 2'd2, 8'hFE, 1'b0, 8'h03);
        run = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", iv, 1'b0);
            chk("stall_ra", ra, 8'h01);
            chk("stall_pc_out", pc_out, 8'h00);
        end
        stall = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 run = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_stall", sb.size(), 0);

        // Reset mid-RUN at PC=5 with run held high
        rom[3] = 8'h30; rom[4] = 8'h87;
        do_reset();
        push(8'h00, 2'd1, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 8'h01);
        push(8'h01, 2'd1, 2'd0, 2'd2, 2'd1, 8'h01, 1'b0, 8'h02);
        push(8'h02, 2'd0, 2'd2, 2'd2, 2'd2, 8'hFE, 1'b0, 8'h03);
        push(8'h03, 2'd0, 2'd3, 2'd0, 2'd0, 8'h00, 1'b0, 8'h04);
        push(8'h04, 2'd2, 2'd0, 2'd1, 2'd3, 8'hFF, 1'b0, 8'h05);
        run = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_reset_ra", ra, 8'h05);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", iv, 1'b0);
        chk("midrst_fields", {opcode, rs, rt, rd, imm, is_jump}, 17'h0);
        chk("midrst_pc_out", pc_out, 8'h00);
        chk("midrst_ra", ra, 8'h00);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("resume_no_capture", iv, 1'b0);
        chk("resume_ra", ra, 8'h00);
        push(8'h00, 2'd1, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 8'h01);
        @(posedge clk);
        #1 run = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_reset", sb.size(), 0);

        // Self-jump at PC=4
        rom[4] = 8'hFF;
        do_reset();
        push(8'h00, 2'd1, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 8'h01);
        push(8'h01, 2'd1, 2'd0, 2'd2, 2'd1, 8'h01, 1'b0, 8'h02);
        push(8'h02, 2'd0, 2'd2, 2'd2, 2'd2, 8'hFE, 1'b0, 8'h03);
        push(8'h03, 2'd0, 2'd3, 2'd0, 2'd0, 8'h00, 1'b0, 8'h04);
        push(8'h04, 2'd3, 2'd3, 2'd3, 2'd3, 8'hFF, 1'b1, 8'h04);
`ifndef IFD_HALT_EN
        push(8'h04, 2'd3, 2'd3, 2'd3, 2'd3, 8'hFF, 1'b1, 8'h04);
        push(8'h04, 2'd3, 2'd3, 2'd3, 2'd3, 8'hFF, 1'b1, 8'h04);
`endif
        run_n(7);
        chk("drain_selfjump", sb.size(), 0);
        chk("selfjump_ra", ra, 8'h04);
`ifdef IFD_HALT_EN
        chk("halted", halted, 1'b1);
`else
        chk("halted", halted, 1'b0);
`endif

        // PC wrap from RESET_PC=FE on the second instance
        do_reset();
        chk("wrap_rst_ra", ra_w, 8'hFE);
        run_w = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("wrap0_valid", iv_w, 1'b1);
        chk("wrap0_pc_out", pc_out_w, 8'hFE);
        chk("wrap0_ra", ra_w, 8'hFF);
        chk("wrap0_op_rd", {opcode_w, rd_w}, 4'b0101);
        @(posedge clk);
        #1;
        chk("wrap1_pc_out", pc_out_w, 8'hFF);
        chk("wrap1_ra", ra_w, 8'h00);
        chk("wrap1_imm", imm_w, 8'hFE);
        @(posedge clk);
        #1;
        chk("wrap2_pc_out", pc_out_w, 8'h00);
        chk("wrap2_ra", ra_w, 8'h01);
        run_w = 1'b0;
        @(posedge clk);
        #1;

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential reader side of the instruction memory interface for the 8-bit teaching CPU.
- Owns the program counter, drives Read_Address, samples the returned 8-bit Instruction, and registers the decoded fields for the datapath.
- Instruction format: [7:6] opcode, [5:4] rs, [3:2] rt, [1:0] rd/imm. Opcode 2'b11 is a PC-relative jump with a 6-bit signed offset in [5:0].
- Sits between the combinational instruction ROM and the register file / ALU control.

Parameters:
- PC_W, 8, width of PC and of Read_Address. PC arithmetic wraps modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- run  input  1  level: 1 = fetch, 0 = stop after the current cycle.
- stall  input  1  1 = freeze PC and the decode registers this cycle.
- Read_Address  output  PC_W  current PC, driven combinationally from the PC register.
- Instruction  input  8  ROM data for Read_Address, valid in the same cycle.
- instr_valid  output  1  1-cycle-per-instruction qualifier for the decoded outputs.
- opcode  output  2  registered Instruction[7:6].
- rs  output  2  registered Instruction[5:4].
- rt  output  2  registered Instruction[3:2].
- rd  output  2  registered Instruction[1:0].
- imm  output  8  Instruction[1:0] sign-extended to 8 bits.
- is_jump  output  1  1 when the registered opcode == 2'b11.
- pc_out  output  PC_W  PC of the instruction now on the decode outputs.
- halted  output  1  halt indicator. Constant 0 unless IFD_HALT_EN is defined.

Behaviour:
- Reset: when reset=1 at a clk edge, the block loads:
  - state=IDLE, PC=RESET_PC
  - instr_valid=0, opcode=rs=rt=rd=0, imm=0, is_jump=0, pc_out=0, halted=0
  - reset has priority over run, stall and any in-flight fetch. Asserting reset mid-RUN aborts the sequence with no partial update.
- States: IDLE, RUN (plus HALT with IFD_HALT_EN).
  - IDLE: PC holds, instr_valid=0. run=1 → RUN at the next edge. No fetch is captured in the IDLE→RUN edge cycle.
  - RUN, run=1, stall=0 (fetch cycle):
    - Capture Instruction (read at Read_Address=PC) into the decode registers.
    - pc_out<=PC, instr_valid<=1.
    - PC<=next_pc.
  - RUN, stall=1: PC and decode registers hold, instr_valid<=0.
  - RUN, run=0: → IDLE. No capture, instr_valid<=0, PC holds. run=0 takes precedence over stall.
- next_pc:
  - Instruction[7:6]==2'b11: PC + 1 + sext(Instruction[5:0]).
  - Otherwise: PC + 1.
  - All sums are truncated to PC_W bits, so 8'hFF+1=8'h00 and 8'h00+1+(-3)=8'hFE.
- Latency: decoded outputs appear 1 cycle after Read_Address presents the instruction. One instruction per unstalled RUN cycle.
- The jump's own decode is presented normally (instr_valid=1, is_jump=1). The target instruction is fetched on the next cycle with no bubble.
- Back-to-back stall toggling loses and duplicates no instruction. Each PC value is captured exactly once per non-jump progression.

Optional Feature:
- Macro: IFD_HALT_EN.
- Defined:
  - A jump with Instruction[5:0]==6'b111111 (self-loop, target == PC) is captured normally with instr_valid=1.
  - The state then enters HALT: halted<=1, PC holds at the jump address, instr_valid=0 in subsequent cycles.
  - run and stall are ignored in HALT. Only reset exits HALT.
- Not defined: halted is tied to 0, HALT does not exist, and a self-jump re-fetches the same instruction every cycle with instr_valid=1.

Test Plan:
- Reset, then run=1; ROM[0]=8'h44, ROM[1]=8'h49, ROM[2]=8'h2A → instr_valid pulses on 3 consecutive cycles; pc_out=0,1,2; opcode=1,1,0; rd=0,1,2; imm=8'h00,8'h01,8'hFE.
- ROM[3]=8'hC2 (jump +2) → is_jump=1, pc_out=3; next Read_Address=6; pc_out=6 on the following cycle.
- stall=1 for 2 cycles at PC=1 → instr_valid=0 for 2 cycles, Read_Address stays 1; after release pc_out=1 appears once, followed by 2.
- RESET_PC=8'hFE, non-jumps at FE and FF → Read_Address sequence FE, FF, 00; pc_out wraps the same way.
- reset asserted mid-RUN at PC=5 with run still 1 → next cycle: state IDLE, PC=RESET_PC, all outputs 0; fetch resumes from RESET_PC one cycle after reset drops.
- With IFD_HALT_EN, ROM[4]=8'hFF → is_jump=1, pc_out=4, then halted=1, Read_Address stuck at 4, instr_valid=0 thereafter. Without the macro → instr_valid=1 every cycle, pc_out=4 repeating.
